// File: rtl/seq_match_ctrl_if.sv
`default_nettype none
// =============================================================================
// seq_match_ctrl_if : configuration, control, serial-bit and status bundle
// Revision 1.0
// =============================================================================
interface seq_match_ctrl_if #(
    parameter int MAX_WIDTH = 8,
    parameter int CNT_WIDTH = 8,
    parameter int TMO_WIDTH = 16,
    parameter int LEN_WIDTH = $clog2(MAX_WIDTH + 1)
);
    logic                 cfg_valid;
    logic                 cfg_ready;
    logic [MAX_WIDTH-1:0] cfg_pattern;
    logic [LEN_WIDTH-1:0] cfg_len;
    logic                 cfg_overlap;
    logic [CNT_WIDTH-1:0] cfg_target;
    logic [TMO_WIDTH-1:0] cfg_timeout;
    logic                 start;
    logic                 abort;
    logic                 bit_valid;
    logic                 bit_in;
    logic                 match_pulse;
    logic [CNT_WIDTH-1:0] match_count;
    logic                 busy;
    logic                 done_valid;
    logic                 done_ready;
    logic [1:0]           done_status;

    modport slave (
        input  cfg_valid, cfg_pattern, cfg_len, cfg_overlap, cfg_target, cfg_timeout,
        input  start, abort, bit_valid, bit_in, done_ready,
        output cfg_ready, match_pulse, match_count, busy, done_valid, done_status
    );

    modport master (
        output cfg_valid, cfg_pattern, cfg_len, cfg_overlap, cfg_target, cfg_timeout,
        output start, abort, bit_valid, bit_in, done_ready,
        input  cfg_ready, match_pulse, match_count, busy, done_valid, done_status
    );
endinterface
`default_nettype wire

// File: rtl/seq_match_ctrl.sv
`default_nettype none
// =============================================================================
// seq_match_ctrl : programmable serial sequence detector with session control
// Revision 1.0
// =============================================================================
module seq_match_ctrl #(
    parameter int MAX_WIDTH = 8,
    parameter int CNT_WIDTH = 8,
    parameter int TMO_WIDTH = 16,
    parameter int LEN_WIDTH = $clog2(MAX_WIDTH + 1)
) (
    input  logic             clk,
    input  logic             rst,
    seq_match_ctrl_if.slave  bus
);
    typedef enum logic [1:0] {
        ST_IDLE   = 2'd0,
        ST_LOADED = 2'd1,
        ST_RUN    = 2'd2,
        ST_REPORT = 2'd3
    } state_t;

    localparam logic [1:0]           STAT_TARGET  = 2'b00;
    localparam logic [1:0]           STAT_TIMEOUT = 2'b01;
    localparam logic [1:0]           STAT_ABORT   = 2'b10;
    localparam logic [LEN_WIDTH-1:0] LEN_MAX      = LEN_WIDTH'(MAX_WIDTH);
    localparam logic [CNT_WIDTH-1:0] CNT_SAT      = {CNT_WIDTH{1'b1}};

    state_t               state_q;
    logic [MAX_WIDTH-1:0] pattern_q;
    logic [LEN_WIDTH-1:0] len_q;
    logic                 overlap_q;
    logic [CNT_WIDTH-1:0] target_q;
    logic [TMO_WIDTH-1:0] timeout_q;
    logic [MAX_WIDTH-1:0] hist_q;
    logic [LEN_WIDTH-1:0] fill_q;
    logic [TMO_WIDTH-1:0] cyc_q;
    logic                 cfg_ready_q;
    logic                 busy_q;
    logic                 match_pulse_q;
    logic [CNT_WIDTH-1:0] match_count_q;
    logic                 done_valid_q;
    logic [1:0]           done_status_q;

    logic [LEN_WIDTH-1:0] len_clamp;
    logic [MAX_WIDTH-1:0] mask;
    logic [MAX_WIDTH-1:0] hist_d;
    logic [LEN_WIDTH-1:0] fill_inc;
    logic [LEN_WIDTH-1:0] fill_d;
    logic [CNT_WIDTH-1:0] count_d;
    logic                 match_hit;
    logic                 target_hit;
    logic                 tmo_hit;
    logic                 cfg_hs;

    always_comb begin
        len_clamp = bus.cfg_len;
        if (bus.cfg_len == '0) begin
            len_clamp = LEN_WIDTH'(1);
        end else if (bus.cfg_len > LEN_MAX) begin
            len_clamp = LEN_MAX;
        end

        mask = '0;
        for (int i = 0; i < MAX_WIDTH; i++) begin
            mask[i] = (LEN_WIDTH'(i) < len_q);
        end

        hist_d   = bus.bit_valid ? {hist_q[MAX_WIDTH-2:0], bus.bit_in} : hist_q;
        fill_inc = (fill_q == LEN_MAX) ? fill_q : fill_q + LEN_WIDTH'(1);

        // Only a freshly shifted bit can complete a match; idle cycles never re-match.
        match_hit = bus.bit_valid && (fill_inc >= len_q) &&
                    (((hist_d ^ pattern_q) & mask) == '0);

        count_d = (match_hit && (match_count_q != CNT_SAT)) ?
                  match_count_q + CNT_WIDTH'(1) : match_count_q;

        if (match_hit && !overlap_q) begin
            fill_d = '0;
        end else if (bus.bit_valid) begin
            fill_d = fill_inc;
        end else begin
            fill_d = fill_q;
        end

        target_hit = match_hit && (target_q != '0) && (count_d == target_q);
        tmo_hit    = (timeout_q != '0) && (cyc_q == timeout_q - TMO_WIDTH'(1));
        cfg_hs     = bus.cfg_valid && cfg_ready_q;
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            state_q       <= ST_IDLE;
            pattern_q     <= '0;
            len_q         <= LEN_WIDTH'(1);
            overlap_q     <= 1'b0;
            target_q      <= '0;
            timeout_q     <= '0;
            hist_q        <= '0;
            fill_q        <= '0;
            cyc_q         <= '0;
            cfg_ready_q   <= 1'b1;
            busy_q        <= 1'b0;
            match_pulse_q <= 1'b0;
            match_count_q <= '0;
            done_valid_q  <= 1'b0;
            done_status_q <= STAT_TARGET;
        end else begin
            match_pulse_q <= 1'b0;

            // cfg_ready is only high in IDLE/LOADED, so this cannot fire elsewhere.
            if (cfg_hs) begin
                pattern_q <= bus.cfg_pattern;
                len_q     <= len_clamp;
                overlap_q <= bus.cfg_overlap;
                target_q  <= bus.cfg_target;
                timeout_q <= bus.cfg_timeout;
            end

            case (state_q)
                ST_IDLE: begin
                    if (cfg_hs) begin
                        state_q <= ST_LOADED;
                    end
                end
                ST_LOADED: begin
                    if (bus.start) begin
                        state_q       <= ST_RUN;
                        cfg_ready_q   <= 1'b0;
                        busy_q        <= 1'b1;
                        hist_q        <= '0;
                        fill_q        <= '0;
                        cyc_q         <= '0;
                        match_count_q <= '0;
                    end
                end
                ST_RUN: begin
                    hist_q        <= hist_d;
                    fill_q        <= fill_d;
                    cyc_q         <= cyc_q + TMO_WIDTH'(1);
                    match_count_q <= count_d;
                    match_pulse_q <= match_hit;
                    if (bus.abort || target_hit || tmo_hit) begin
                        state_q      <= ST_REPORT;
                        busy_q       <= 1'b0;
                        done_valid_q <= 1'b1;
                        if (bus.abort) begin
                            done_status_q <= STAT_ABORT;
                        end else if (target_hit) begin
                            done_status_q <= STAT_TARGET;
                        end else begin
                            done_status_q <= STAT_TIMEOUT;
                        end
                    end
                end
                ST_REPORT: begin
                    if (bus.done_ready) begin
                        state_q      <= ST_LOADED;
                        done_valid_q <= 1'b0;
                        cfg_ready_q  <= 1'b1;
                    end
                end
                default: begin
                    state_q <= ST_IDLE;
                end
            endcase
        end
    end

    assign bus.cfg_ready   = cfg_ready_q;
    assign bus.busy        = busy_q;
    assign bus.match_pulse = match_pulse_q;
    assign bus.match_count = match_count_q;
    assign bus.done_valid  = done_valid_q;
    assign bus.done_status = done_status_q;
endmodule
`default_nettype wire

// File: tb/tb_seq_match_ctrl.sv
`default_nettype none
// =============================================================================
// tb_seq_match_ctrl : directed sessions with scoreboard-checked match/done events
// Revision 1.0
// =============================================================================
module tb_seq_match_ctrl;
    localparam int MAX_WIDTH = 8;
    localparam int CNT_WIDTH = 8;
    localparam int TMO_WIDTH = 16;
    localparam int LEN_WIDTH = $clog2(MAX_WIDTH + 1);

    typedef struct {
        bit is_done;
        int count;
        int status;
        int runcyc;
    } exp_t;

    logic clk;
    logic rst;
    exp_t sb[$];
    int   n_checks;
    int   n_fail;
    int   run_cnt;

    seq_match_ctrl_if #(
        .MAX_WIDTH(MAX_WIDTH), .CNT_WIDTH(CNT_WIDTH),
        .TMO_WIDTH(TMO_WIDTH), .LEN_WIDTH(LEN_WIDTH)
    ) bus ();

    seq_match_ctrl #(
        .MAX_WIDTH(MAX_WIDTH), .CNT_WIDTH(CNT_WIDTH),
        .TMO_WIDTH(TMO_WIDTH), .LEN_WIDTH(LEN_WIDTH)
    ) dut (
        .clk (clk),
        .rst (rst),
        .bus (bus)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    task automatic check(input string name, input longint act, input longint exp);
        n_checks++;
        if (act != exp) begin
            n_fail++;
            $display("FAIL %s: got %0d, expected %0d", name, act, exp);
        end
    endtask

    function automatic void push_match(input int c);
        exp_t e;
        e.is_done = 1'b0; e.count = c; e.status = 0; e.runcyc = -1;
        sb.push_back(e);
    endfunction

    function automatic void push_done(input int st, input int c, input int r);
        exp_t e;
        e.is_done = 1'b1; e.count = c; e.status = st; e.runcyc = r;
        sb.push_back(e);
    endfunction

    // Monitor: pops one expectation per presented match pulse or done handshake.
    always @(negedge clk) begin
        exp_t e;
        if (rst) begin
            run_cnt = 0;
        end else begin
            if (bus.busy) run_cnt++;
            if (bus.match_pulse) begin
                if (sb.size() == 0) begin
                    check("unexpected_match_pulse", 1, 0);
                end else begin
                    e = sb.pop_front();
                    check("event_is_match", e.is_done ? 0 : 1, 1);
                    check("match_count_at_pulse", bus.match_count, e.count);
                end
            end
            if (bus.done_valid && bus.done_ready) begin
                if (sb.size() == 0) begin
                    check("unexpected_done", 1, 0);
                end else begin
                    e = sb.pop_front();
                    check("event_is_done", e.is_done ? 1 : 0, 1);
                    check("done_status", bus.done_status, e.status);
                    check("done_match_count", bus.match_count, e.count);
                    if (e.runcyc >= 0) check("run_cycles", run_cnt, e.runcyc);
                end
                run_cnt = 0;
            end
        end
    end

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic configure(input logic [7:0] pat, input int len, input bit ovl,
                             input int tgt, input int tmo, input bit with_start);
        check("cfg_ready_before_cfg", bus.cfg_ready, 1);
        bus.cfg_valid   = 1'b1;
        bus.cfg_pattern = pat;
        bus.cfg_len     = LEN_WIDTH'(len);
        bus.cfg_overlap = ovl;
        bus.cfg_target  = CNT_WIDTH'(tgt);
        bus.cfg_timeout = TMO_WIDTH'(tmo);
        bus.start       = with_start;
        tick();
        bus.cfg_valid = 1'b0;
        bus.start     = 1'b0;
    endtask

    task automatic do_start();
        bus.start = 1'b1;
        tick();
        bus.start = 1'b0;
        check("busy_after_start", bus.busy, 1);
    endtask

    task automatic send_bits(input logic [15:0] bits, input int n, input bit gapped,
                             input int abort_at);
        for (int i = n - 1; i >= 0; i--) begin
            bus.bit_valid = 1'b1;
            bus.bit_in    = bits[i];
            bus.abort     = ((n - 1 - i) == abort_at);
            tick();
            bus.abort = 1'b0;
            if (gapped) begin
                bus.bit_valid = 1'b0;
                bus.bit_in    = 1'b0;
                tick();
            end
        end
        bus.bit_valid = 1'b0;
        bus.bit_in    = 1'b0;
    endtask

    task automatic apply_reset();
        rst = 1'b1;
        tick();
        rst = 1'b0;
    endtask

    task automatic wait_idle(input int budget);
        int k;
        k = 0;
        while (!bus.cfg_ready && k < budget) begin
            tick();
            k++;
        end
        if (!bus.cfg_ready) begin
            check("session_end_within_budget", 0, 1);
            sb.delete();
            apply_reset();
        end
    endtask

    initial begin
        n_checks = 0;
        n_fail   = 0;
        run_cnt  = 0;
        bus.cfg_valid   = 1'b0;
        bus.cfg_pattern = '0;
        bus.cfg_len     = '0;
        bus.cfg_overlap = 1'b0;
        bus.cfg_target  = '0;
        bus.cfg_timeout = '0;
        bus.start       = 1'b0;
        bus.abort       = 1'b0;
        bus.bit_valid   = 1'b0;
        bus.bit_in      = 1'b0;
        bus.done_ready  = 1'b1;
        rst = 1'b1;
        tick();
        tick();
        rst = 1'b0;

        check("rst_cfg_ready",   bus.cfg_ready, 1);
        check("rst_busy",        bus.busy, 0);
        check("rst_match_pulse", bus.match_pulse, 0);
        check("rst_match_count", bus.match_count, 0);
        check("rst_done_valid",  bus.done_valid, 0);
        check("rst_done_status", bus.done_status, 0);

        // Overlapping 1001, target 2
        configure(8'h09, 4, 1'b1, 2, 0, 1'b0);
        push_match(1); push_match(2); push_done(0, 2, 7);
        do_start();
        send_bits(16'b1001001, 7, 1'b0, -1);
        wait_idle(50);

        // Non-overlapping, timeout 20
        configure(8'h09, 4, 1'b0, 0, 20, 1'b0);
        push_match(1); push_done(1, 1, 20);
        do_start();
        send_bits(16'b1001001, 7, 1'b0, -1);
        wait_idle(50);

        // Gapped 110, result held until done_ready
        configure(8'h06, 3, 1'b1, 0, 12, 1'b0);
        bus.done_ready = 1'b0;
        push_match(1); push_done(1, 1, 12);
        do_start();
        send_bits(16'b110, 3, 1'b1, -1);
        for (int k = 0; k < 40 && !bus.done_valid; k++) tick();
        tick(); tick(); tick();
        check("done_held_valid",  bus.done_valid, 1);
        check("done_held_status", bus.done_status, 1);
        check("held_cfg_ready",   bus.cfg_ready, 0);
        bus.done_ready = 1'b1;
        tick();
        check("cfg_ready_after_done", bus.cfg_ready, 1);

        // Abort on the same edge as the target-completing bit
        configure(8'h09, 4, 1'b1, 2, 0, 1'b0);
        push_match(1); push_match(2); push_done(2, 2, 7);
        do_start();
        send_bits(16'b1001001, 7, 1'b0, 6);
        wait_idle(50);

        // len 0 -> 1, configured together with start in LOADED
        push_match(1); push_match(2); push_match(3); push_done(0, 3, 4);
        configure(8'h01, 0, 1'b1, 3, 0, 1'b1);
        check("busy_cfg_and_start", bus.busy, 1);
        send_bits(16'b1011, 4, 1'b0, -1);
        wait_idle(50);
        check("count_kept_in_loaded", bus.match_count, 3);

        // len 12 -> 8
        configure(8'hA5, 12, 1'b0, 1, 0, 1'b0);
        push_match(1); push_done(0, 1, 10);
        do_start();
        send_bits(16'b1110100101, 10, 1'b0, -1);
        wait_idle(50);

        // start in IDLE is ignored
        apply_reset();
        bus.start = 1'b1;
        tick();
        bus.start = 1'b0;
        tick();
        check("idle_start_busy",      bus.busy, 0);
        check("idle_start_cfg_ready", bus.cfg_ready, 1);

        // Reset mid-RUN after 3 matches
        configure(8'h01, 1, 1'b1, 0, 0, 1'b0);
        push_match(1); push_match(2); push_match(3);
        do_start();
        send_bits(16'b111, 3, 1'b0, -1);
        tick();
        apply_reset();
        check("mid_rst_cfg_ready",   bus.cfg_ready, 1);
        check("mid_rst_busy",        bus.busy, 0);
        check("mid_rst_match_count", bus.match_count, 0);
        check("mid_rst_done_valid",  bus.done_valid, 0);
        bus.start = 1'b1;
        tick();
        bus.start = 1'b0;
        tick();
        check("post_rst_start_busy", bus.busy, 0);

        tick();
        check("scoreboard_drained", sb.size(), 0);
        $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
        $finish;
    end

    initial begin
        #200000;
        $display("FAIL watchdog: got timeout, expected completion");
        $fatal(1, "watchdog expired");
    end
endmodule
`default_nettype wire

// File: doc/seq_match_ctrl.md
# seq_match_ctrl

Run-time programmable sequence-detection controller. It accepts a pattern, length, overlap mode, match target and timeout over a valid/ready configuration port. It then arms an internal shift-register matcher on a serial bit stream, counts matches and reports completion over a valid/ready status port. It sits between the control processor and the serial input, replacing compile-time pattern selection with a sequenced detection session.

## Interface
- MAX_WIDTH, 8: maximum pattern length in bits (≥2)
- CNT_WIDTH, 8: width of match target and match counter
- TMO_WIDTH, 16: width of timeout in clock cycles
- LEN_WIDTH, $clog2(MAX_WIDTH+1): width of cfg_len
- clk  input  1  single clock, rising edge
- rst  input  1  synchronous, active-high reset
- cfg_valid  input  1  configuration offer
- cfg_ready  output  1  configuration accepted when high with cfg_valid
- cfg_pattern  input  MAX_WIDTH  pattern; bit [len-1] is the oldest bit, bit 0 the newest
- cfg_len  input  LEN_WIDTH  pattern length
- cfg_overlap  input  1  1 = overlapping detection, 0 = non-overlapping
- cfg_target  input  CNT_WIDTH  matches required to finish; 0 = unlimited
- cfg_timeout  input  TMO_WIDTH  max RUN cycles; 0 = disabled
- start  input  1  single-cycle request to begin a session
- abort  input  1  terminate the running session
- bit_valid  input  1  bit_in is valid this cycle
- bit_in  input  1  serial data bit
- match_pulse  output  1  one-cycle pulse per detected match
- match_count  output  CNT_WIDTH  matches in current or last session
- busy  output  1  high in RUN
- done_valid  output  1  session result available
- done_ready  input  1  result consumed
- done_status  output  2  00 target reached, 01 timeout, 10 aborted

## Operation
- FSM states: IDLE, LOADED, RUN, REPORT. Reset enters IDLE.
- IDLE: cfg_ready=1. A handshake (cfg_valid & cfg_ready) latches all cfg_* fields and moves to LOADED. start is ignored.
- LOADED: cfg_ready=1. A new handshake overwrites the configuration and stays in LOADED. start moves to RUN. If start and a handshake occur in the same cycle, the new configuration is latched and used.
- Entering RUN clears the history register, fill counter, match_count and cycle counter.
- RUN: cfg_ready=0. Each bit_valid cycle shifts bit_in into history LSB. The fill counter saturates at MAX_WIDTH.
- A match occurs when fill ≥ len and history[len-1:0] == pattern[len-1:0].
- After a match with overlap=1, history and fill are kept. With overlap=0, fill is cleared to 0, so the next match requires len fresh bits.
- Length clamping: cfg_len=0 is treated as 1; cfg_len>MAX_WIDTH is treated as MAX_WIDTH.
- match_count increments per match and saturates at all-ones.
- Leaving RUN, checked every RUN cycle with priority abort > target > timeout:
  - abort=1 → REPORT, status 10.
  - target≠0 and this match makes match_count == target → REPORT, status 00.
  - timeout≠0 and the cycle counter reaches cfg_timeout-1 → REPORT, status 01.
- REPORT: done_valid=1, done_status is held stable. done_valid & done_ready → LOADED, keeping the configuration. Bits are ignored in REPORT.
- abort outside RUN has no effect. bit_valid outside RUN has no effect.
- rst in any state returns to IDLE within one edge and discards the configuration.

## Timing
- Reset values:
  - cfg_ready=1
  - busy=0, match_pulse=0, match_count=0
  - done_valid=0, done_status=00
- start sampled at edge N: busy=1 from cycle N+1.
- Match latency: a bit accepted at edge N completing a match gives match_pulse=1 and the incremented match_count during cycle N+1 (registered output, one cycle).
- Target termination: done_valid rises in the same cycle as the final match_pulse, and busy falls that cycle.
- Timeout: RUN lasts exactly cfg_timeout cycles; done_valid=1 in the following cycle.
- Abort at edge N: done_valid=1 in cycle N+1. A match completing on the same edge is still counted and pulsed.
- done_valid is held until done_ready. Handshake at edge N: cfg_ready=1 from N+1.
- Back-to-back bit_valid every cycle is supported with no bubbles.

## Test plan
- Overlap count: pattern 1001, len 4, overlap 1, target 2. Stream 1001001 → match_pulse after bits 4 and 7, done_status 00, match_count 2.
- Non-overlap: same stream with overlap 0, target 0, timeout 20 → one match only, timeout after 20 RUN cycles, status 01, match_count 1.
- Gapped input: pattern 110, len 3. Bits 1,1,0 with bit_valid low on alternate cycles → exactly one match; idle cycles do not shift history.
- Abort precedence: abort asserted on the same edge as the final bit of the target match → status 10, match_count incremented, match_pulse seen.
- Config rules:
  - cfg_len=0 with pattern LSB 1 → every 1 bit matches.
  - cfg_len=12 with MAX_WIDTH=8 → behaves as len 8.
  - start in IDLE → no RUN.
- Reset mid-RUN after 3 matches: rst for one cycle → IDLE, cfg_ready=1, busy=0, match_count=0, done_valid=0. A subsequent start without new configuration is ignored.
